seqdet_scan_ctrl: RTL and testbench

Controller that sequences the serial sequence-detector datapath (`x`, `clk`, `low`). It accepts a W-bit parallel word under a start/busy/done handshake and drives it MSB-first onto the detector's `x` input, one bit per clock. It samples the detector's `low` output aligned to each driven bit and reports the match count. It sits between a parallel host and the detector instance, which it drives but does not contain.

---
 rtl/seqdet_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_seqdet_scan_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seqdet_scan_ctrl.sv
// Scan controller for the serial "x -> low" sequence detector.
// Takes a parallel word under start/busy/done, shifts it MSB-first onto x,
// samples low DET_LAT cycles behind each driven bit and reports a saturating
// match count. The detector itself lives outside this block.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start, x parked at IDLE_X
// ST_SHIFT | driving word bits onto x, one per cycle, W cycles
// ST_DRAIN | x parked, waiting DET_LAT cycles for the last samples to land
// ST_DONE  | one-cycle done pulse; start here begins the next scan at once
module seqdet_scan_ctrl #(
   parameter int   W       = 8,
   parameter int   DET_LAT = 1,
   parameter int   CNT_W   = 4,
   parameter logic IDLE_X  = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [W-1:0]     word,
   output logic             x,
   input  logic             low,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt,
   output logic             found
);

   localparam int BW = $clog2(W);
   localparam int TW = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;
   localparam logic [BW-1:0]    BIT_LAST   = BW'(W - 1);
   localparam logic [TW-1:0]    DRAIN_LOAD = TW'(DET_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [W-1:0]       sreg;
   logic [BW-1:0]      bit_cnt;
   logic [TW-1:0]      drain_tmr;
   logic [DET_LAT-1:0] smp_pipe;
   logic               accept;
   logic               in_shift;
   logic               smp_en;
   logic               x_nxt;
   logic               busy_nxt;
   logic               done_nxt;

   assign in_shift = (state == ST_SHIFT);
   // low reflects the bit driven DET_LAT cycles earlier, so the sample window
   // is the SHIFT window delayed by DET_LAT.
   assign smp_en   = smp_pipe[DET_LAT-1];

   // Next state and next values of the registered outputs.
   always_comb begin
      accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
      state_nxt = state;
      x_nxt     = IDLE_X;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               state_nxt = ST_SHIFT;
               x_nxt     = word[W-1];
               busy_nxt  = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            busy_nxt = 1'b1;
            if (bit_cnt == BIT_LAST) begin
               state_nxt = ST_DRAIN;
            end else begin
               x_nxt = sreg[W-2];
            end
         end
         ST_DRAIN: begin
            if (drain_tmr == '0) begin
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
            end else begin
               busy_nxt = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register and registered handshake/serial outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         x     <= IDLE_X;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         x     <= x_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Shift register, bit index and drain down-counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg      <= '0;
         bit_cnt   <= '0;
         drain_tmr <= '0;
      end else if (accept) begin
         sreg    <= word;
         bit_cnt <= '0;
      end else if (state == ST_SHIFT) begin
         sreg <= {sreg[W-2:0], 1'b0};
         if (bit_cnt == BIT_LAST) begin
            bit_cnt   <= '0;
            drain_tmr <= DRAIN_LOAD;
         end else begin
            bit_cnt <= bit_cnt + BW'(1);
         end
      end else if ((state == ST_DRAIN) && (drain_tmr != '0)) begin
         drain_tmr <= drain_tmr - TW'(1);
      end
   end

   // Delay line marking which edges carry a valid detector sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         smp_pipe <= '0;
      end else begin
         smp_pipe <= DET_LAT'({smp_pipe, in_shift});
      end
   end

   // Saturating match counter; found tracks it on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         match_cnt <= '0;
         found     <= 1'b0;
      end else if (accept) begin
         match_cnt <= '0;
         found     <= 1'b0;
      end else if (smp_en && low && (match_cnt != CNT_MAX)) begin
         match_cnt <= match_cnt + CNT_W'(1);
         found     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seqdet_scan_ctrl.sv
// Bench for seqdet_scan_ctrl: two instances (default and W=16/CNT_W=2), each
// driving an overlapping Moore "010" detector model with one cycle latency.
module tb_seqdet_scan_ctrl;

   localparam int L = 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        start_a = 1'b0;
   logic [7:0]  word_a = '0;
   logic        x_a, busy_a, done_a, found_a, low_a;
   logic [3:0]  cnt_a;

   logic        start_b = 1'b0;
   logic [15:0] word_b = '0;
   logic        x_b, busy_b, done_b, found_b, low_b;
   logic [1:0]  cnt_b;

   int vectors = 0;
   int miscompares = 0;
   logic chk_en = 1'b0;

   seqdet_scan_ctrl dut_a (
      .clk(clk), .reset(reset), .start(start_a), .word(word_a), .x(x_a),
      .low(low_a), .busy(busy_a), .done(done_a), .match_cnt(cnt_a), .found(found_a)
   );

   seqdet_scan_ctrl #(.W(16), .DET_LAT(1), .CNT_W(2), .IDLE_X(1'b1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .word(word_b), .x(x_b),
      .low(low_b), .busy(busy_b), .done(done_b), .match_cnt(cnt_b), .found(found_b)
   );

   // Moore "010" detectors: low during a cycle reflects the last three bits
   // seen at previous edges.
   logic [2:0] hist_a = 3'b111;
   logic [2:0] hist_b = 3'b111;
   always @(posedge clk) begin
      hist_a <= {hist_a[1:0], x_a};
      hist_b <= {hist_b[1:0], x_b};
   end
   assign low_a = (hist_a == 3'b010);
   assign low_b = (hist_b == 3'b010);

   // Reference model in scan-cycle terms: mc = cycle number since accept
   // (0 = not scanning), mcnt = matches counted so far.
   int          mw[2]    = '{8, 16};
   int          mcmax[2] = '{15, 3};
   int          mc[2]    = '{0, 0};
   int          mcnt[2]  = '{0, 0};
   logic [15:0] mword[2] = '{16'h0, 16'h0};

   task automatic model_step(input int i, input logic st, input logic [15:0] w, input logic lo);
      int last;
      last = mw[i] + L + 1;
      if (mc[i] >= L + 1 && mc[i] <= mw[i] + L && lo && mcnt[i] < mcmax[i])
         mcnt[i] = mcnt[i] + 1;
      if ((mc[i] == 0 || mc[i] == last) && st) begin
         mc[i] = 1;
         mword[i] = w;
         mcnt[i] = 0;
      end else if (mc[i] == last) begin
         mc[i] = 0;
      end else if (mc[i] > 0) begin
         mc[i] = mc[i] + 1;
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            mc[i] = 0;
            mcnt[i] = 0;
         end
      end else begin
         model_step(0, start_a, {8'h00, word_a}, low_a);
         model_step(1, start_b, word_b, low_b);
      end
   end

   function automatic int exp_x(input int i);
      if (mc[i] >= 1 && mc[i] <= mw[i]) return int'(mword[i][mw[i] - mc[i]]);
      return 1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors = vectors + 1;
      if (act != exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (!reset && chk_en) begin
         chk("a.x", int'(x_a), exp_x(0));
         chk("a.busy", int'(busy_a), int'(mc[0] >= 1 && mc[0] <= mw[0] + L));
         chk("a.done", int'(done_a), int'(mc[0] == mw[0] + L + 1));
         chk("a.match_cnt", int'(cnt_a), mcnt[0]);
         chk("a.found", int'(found_a), int'(mcnt[0] != 0));
         chk("b.x", int'(x_b), exp_x(1));
         chk("b.busy", int'(busy_b), int'(mc[1] >= 1 && mc[1] <= mw[1] + L));
         chk("b.done", int'(done_b), int'(mc[1] == mw[1] + L + 1));
         chk("b.match_cnt", int'(cnt_b), mcnt[1]);
         chk("b.found", int'(found_b), int'(mcnt[1] != 0));
      end
   end

   task automatic pulse_a(input logic [7:0] w);
      start_a = 1'b1;
      word_a = w;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic pulse_b(input logic [15:0] w);
      start_b = 1'b1;
      word_b = w;
      @(negedge clk);
      start_b = 1'b0;
   endtask

   int xs[11] = '{0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 1};

   initial begin
      #2 reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.x_a", int'(x_a), 1);
      chk("rst.busy_a", int'(busy_a), 0);
      chk("rst.done_a", int'(done_a), 0);
      chk("rst.cnt_a", int'(cnt_a), 0);
      chk("rst.found_a", int'(found_a), 0);
      chk("rst.x_b", int'(x_b), 1);
      reset = 1'b0;
      chk_en = 1'b1;
      repeat (4) @(negedge clk);

      // Basic scan, literal x/busy/done per cycle
      pulse_a(8'b0101_0100);
      for (int n = 1; n <= 11; n++) begin
         chk("t1.x", int'(x_a), xs[n-1]);
         chk("t1.busy", int'(busy_a), int'(n <= 9));
         chk("t1.done", int'(done_a), int'(n == 10));
         if (n == 10) begin
            chk("t1.cnt", int'(cnt_a), 3);
            chk("t1.found", int'(found_a), 1);
         end
         @(negedge clk);
      end

      // All ones, then all zeros
      pulse_a(8'hFF);
      repeat (9) @(negedge clk);
      chk("t2ff.done", int'(done_a), 1);
      chk("t2ff.cnt", int'(cnt_a), 0);
      chk("t2ff.found", int'(found_a), 0);
      repeat (2) @(negedge clk);
      pulse_a(8'h00);
      repeat (9) @(negedge clk);
      chk("t2z.done", int'(done_a), 1);
      chk("t2z.cnt", int'(cnt_a), 0);
      chk("t2z.found", int'(found_a), 0);
      chk("t2z.x", int'(x_a), 1);
      repeat (2) @(negedge clk);

      // start in SHIFT and DRAIN is ignored
      pulse_a(8'b0101_0100);
      repeat (2) @(negedge clk);
      start_a = 1'b1;
      word_a = 8'hFF;
      @(negedge clk);
      start_a = 1'b0;
      repeat (5) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("t3.done", int'(done_a), 1);
      chk("t3.cnt", int'(cnt_a), 3);
      @(negedge clk);
      chk("t3.idle_busy", int'(busy_a), 0);
      chk("t3.idle_done", int'(done_a), 0);
      repeat (2) @(negedge clk);

      // Back-to-back start in DONE
      pulse_a(8'b0101_0100);
      repeat (9) @(negedge clk);
      start_a = 1'b1;
      word_a = 8'b0100_0000;
      chk("t4.done1", int'(done_a), 1);
      chk("t4.cnt1", int'(cnt_a), 3);
      @(negedge clk);
      start_a = 1'b0;
      chk("t4.busy2", int'(busy_a), 1);
      chk("t4.cnt_clr", int'(cnt_a), 0);
      repeat (9) @(negedge clk);
      chk("t4.done2", int'(done_a), 1);
      chk("t4.cnt2", int'(cnt_a), 1);
      chk("t4.found2", int'(found_a), 1);
      repeat (2) @(negedge clk);

      // Asynchronous reset mid-scan
      pulse_a(8'b0101_0100);
      repeat (3) @(negedge clk);
      chk("t5.busy_pre", int'(busy_a), 1);
      reset = 1'b1;
      #1;
      chk("t5.busy", int'(busy_a), 0);
      chk("t5.done", int'(done_a), 0);
      chk("t5.cnt", int'(cnt_a), 0);
      chk("t5.x", int'(x_a), 1);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("t5.no_done", int'(done_a), 0);
      pulse_a(8'b0101_0100);
      repeat (9) @(negedge clk);
      chk("t5.done_after", int'(done_a), 1);
      chk("t5.cnt_after", int'(cnt_a), 3);
      repeat (2) @(negedge clk);

      // Wide word, narrow counter: saturation
      pulse_b(16'h5555);
      repeat (16) @(negedge clk);
      chk("t6.done17", int'(done_b), 0);
      chk("t6.busy17", int'(busy_b), 1);
      @(negedge clk);
      chk("t6.done18", int'(done_b), 1);
      chk("t6.cnt", int'(cnt_b), 3);
      chk("t6.found", int'(found_b), 1);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
